// File: rtl/comp_float_reg.sv
// Registered IEEE-754 binary32 comparator: one-hot greater/equal/less flag plus
// an unordered indication for NaN operands, one cycle behind in_valid.
module comp_float_reg #(
  parameter bit DAZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [2:0]  flag,
  output logic        unordered
);

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned MAG_W = EXP_W + MAN_W;

  localparam logic [2:0] FLAG_GT = 3'b100;
  localparam logic [2:0] FLAG_EQ = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;
  localparam logic [2:0] FLAG_UN = 3'b000;

  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_nan, b_nan;
  logic             a_zero, b_zero;
  logic [MAG_W-1:0] a_mag, b_mag;
  logic [2:0]       flag_c;
  logic             unordered_c;

  // Field decode and special-value classification
  always_comb begin
    a_sign = a[31];
    b_sign = b[31];
    a_exp  = a[30:23];
    b_exp  = b[30:23];
    a_man  = a[22:0];
    b_man  = b[22:0];
    a_nan  = (a_exp == '1) && (a_man != '0);
    b_nan  = (b_exp == '1) && (b_man != '0);
    a_zero = (a_exp == '0) && (DAZ || (a_man == '0));
    b_zero = (b_exp == '0) && (DAZ || (b_man == '0));
    // Flushed subnormals must order as zero magnitude against normals
    a_mag  = a_zero ? MAG_W'(0) : {a_exp, a_man};
    b_mag  = b_zero ? MAG_W'(0) : {b_exp, b_man};
  end

  // Relation decode in priority order
  always_comb begin
    flag_c      = FLAG_UN;
    unordered_c = 1'b0;
    if (a_nan || b_nan) begin
      unordered_c = 1'b1;
    end else if (a_zero && b_zero) begin
      flag_c = FLAG_EQ;
    end else if (a_sign != b_sign) begin
      flag_c = a_sign ? FLAG_LT : FLAG_GT;
    end else if (a_mag == b_mag) begin
      flag_c = FLAG_EQ;
    end else if ((a_mag > b_mag) ^ a_sign) begin
      flag_c = FLAG_GT;
    end else begin
      flag_c = FLAG_LT;
    end
  end

  // Result register; flag/unordered hold while in_valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      flag      <= 3'b000;
      unordered <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        flag      <= flag_c;
        unordered <= unordered_c;
      end
    end
  end

endmodule

// File: tb/tb_comp_float_reg.sv
// Directed bench for comp_float_reg: one DAZ=0 and one DAZ=1 instance share
// the same operands so subnormal handling is checked side by side.
module tb_comp_float_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a, b;
  logic        out_valid, unordered;
  logic [2:0]  flag;
  logic        out_valid_d, unordered_d;
  logic [2:0]  flag_d;

  int n_cmp = 0;
  int n_bad = 0;

  comp_float_reg #(.DAZ(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .flag(flag), .unordered(unordered)
  );

  comp_float_reg #(.DAZ(1'b1)) dut_daz (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid_d), .flag(flag_d), .unordered(unordered_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f0;
    logic        un;
    logic [2:0]  f1;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{32'h3f800000, 32'h40000000, 3'b001, 1'b0, 3'b001};
    vecs[1]  = '{32'h40000000, 32'h3f800000, 3'b100, 1'b0, 3'b100};
    vecs[2]  = '{32'h40000000, 32'h40000000, 3'b010, 1'b0, 3'b010};
    vecs[3]  = '{32'hbf800000, 32'hc0000000, 3'b100, 1'b0, 3'b100};
    vecs[4]  = '{32'hbf800000, 32'h3f800000, 3'b001, 1'b0, 3'b001};
    vecs[5]  = '{32'h00000000, 32'h80000000, 3'b010, 1'b0, 3'b010};
    vecs[6]  = '{32'h7fc00000, 32'h3f800000, 3'b000, 1'b1, 3'b000};
    vecs[7]  = '{32'h7f800000, 32'h7f7fffff, 3'b100, 1'b0, 3'b100};
    vecs[8]  = '{32'hff800000, 32'hff800000, 3'b010, 1'b0, 3'b010};
    vecs[9]  = '{32'h00000001, 32'h00000000, 3'b100, 1'b0, 3'b010};
    vecs[10] = '{32'h80000001, 32'h00000000, 3'b001, 1'b0, 3'b010};
    vecs[11] = '{32'h3f800000, 32'h7f800001, 3'b000, 1'b1, 3'b000};
    vecs[12] = '{32'hff800000, 32'h7f800000, 3'b001, 1'b0, 3'b001};
    vecs[13] = '{32'h00000002, 32'h00000001, 3'b100, 1'b0, 3'b010};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_unord", 32'(unordered), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream: each result checked one edge after its operands
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b;
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_flag", i), 32'(flag), 32'(vecs[i].f0));
      chk($sformatf("v%0d_unord", i), 32'(unordered), 32'(vecs[i].un));
      chk($sformatf("v%0d_flag_daz", i), 32'(flag_d), 32'(vecs[i].f1));
    end

    // Drop in_valid: out_valid clears, flag holds the last result
    @(negedge clk);
    in_valid = 1'b0; a = 32'h3f800000; b = 32'h40000000;
    @(posedge clk); #1;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_flag", 32'(flag), 32'b100);
    chk("idle_flag_daz", 32'(flag_d), 32'b010);

    // NaN then idle: unordered must also hold
    @(negedge clk);
    in_valid = 1'b1; a = 32'h7fc00000; b = 32'h00000000;
    @(negedge clk);
    in_valid = 1'b0; a = 32'h40000000; b = 32'h3f800000;
    @(posedge clk); #1;
    chk("idle_unord", 32'(unordered), 32'd1);

    // Asynchronous reset mid-stream with in_valid high
    @(negedge clk);
    in_valid = 1'b1; a = 32'h40000000; b = 32'h3f800000;
    @(posedge clk); #1;
    chk("pre_rst_flag", 32'(flag), 32'b100);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_flag", 32'(flag), 32'd0);
    chk("async_rst_unord", 32'(unordered), 32'd0);
    @(posedge clk); #1;
    chk("held_rst_valid", 32'(out_valid), 32'd0);
    chk("held_rst_flag", 32'(flag), 32'd0);

    // First capture after release
    @(negedge clk);
    rst_n = 1'b1; a = 32'hbf800000; b = 32'h3f800000;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_flag", 32'(flag), 32'b001);

    @(negedge clk);
    in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/comp_float_reg.md
Name: comp_float_reg

Overview:
- Registered IEEE-754 single-precision magnitude/sign comparator.
- Takes two 32-bit floats and produces a one-hot 3-bit relation flag: greater, equal or less, plus an unordered indication for NaN operands.
- Used by the neural-net datapath for max/threshold decisions.
- Result is registered with one-cycle latency behind a valid strobe.

Parameters:
- DAZ, 0, denormals-are-zero. When 1, any operand with exponent 0 is treated as ±0 before comparison. When 0, subnormals compare by exact value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b are valid this cycle.
- a  input  32  operand A, IEEE-754 binary32.
- b  input  32  operand B, IEEE-754 binary32.
- out_valid  output  1  flag/unordered hold the result for the operands sampled on the previous edge.
- flag  output  3  one-hot relation: bit2 = A>B, bit1 = A==B, bit0 = A<B.
- unordered  output  1  at least one operand was NaN.

Behaviour:
- Reset (rst_n low, asynchronous, effective immediately regardless of clk):
  - out_valid=0, flag=3'b000, unordered=0.
  - These values are held while rst_n is low. The first capture happens on the first rising edge after release.
- Latency: 1 cycle, throughput 1 per cycle.
  - On a rising edge with in_valid=1: register the comparison result of a/b and set out_valid=1.
  - On a rising edge with in_valid=0: out_valid=0, and flag/unordered hold their last value.
- Field decode per operand: sign s=[31], exponent e=[30:23], mantissa m=[22:0].
  - NaN: e=8'hFF and m!=0.
  - Infinity: e=8'hFF and m=0.
  - Zero: e=0 and m=0. With DAZ=1, any e=0 counts as zero.
- Comparison rules, applied in priority order:
  1. Either operand NaN: flag=3'b000, unordered=1.
  2. Both zero, any signs: equal, so +0 == -0.
  3. Signs differ (and not both zero): the positive operand is greater.
  4. Both positive: compare {e,m} as a 31-bit unsigned value; larger is greater.
  5. Both negative: compare {e,m} unsigned; the larger magnitude is less.
  6. Equal bit patterns (non-NaN): equal.
- Infinities are ordered naturally by these rules: +inf > any finite, -inf < any finite, and inf == inf of the same sign.
- Output encoding: flag is exactly one-hot whenever unordered=0, and exactly 3'b000 when unordered=1. No other flag value is legal.
- Comparison logic is purely combinational from a/b into the output register. There are no internal multi-cycle states.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1 -> outputs go to out_valid=0, flag=000, unordered=0 immediately, without waiting for a clock edge.
- a=3f800000 (1.0), b=40000000 (2.0), in_valid=1 -> next cycle flag=001, unordered=0, out_valid=1.
- a=40000000, b=3f800000 -> flag=100. Then a=b=40000000 -> flag=010.
- Negatives and sign mix:
  - a=bf800000 (-1.0), b=c0000000 (-2.0) -> flag=100.
  - a=bf800000, b=3f800000 -> flag=001.
  - a=00000000, b=80000000 (+0 vs -0) -> flag=010.
- Specials:
  - a=7fc00000 (NaN), b=3f800000 -> flag=000, unordered=1.
  - a=7f800000 (+inf), b=7f7fffff (max finite) -> flag=100.
  - a=ff800000 (-inf), b=ff800000 -> flag=010.
- Pipeline:
  - Back-to-back operands on consecutive cycles -> each result appears exactly one cycle later.
  - Drop in_valid -> out_valid=0 on the next edge while flag holds its previous value.
  - With DAZ=1: a=00000001, b=00000000 -> flag=010; the same operands with DAZ=0 -> flag=100.
